// File: rtl/coin_sender.sv
// coin_sender: pays a requested amount into the vending machine by pulsing its coin inputs.
// `a` is a 2-unit coin, `b` a 1-unit coin; coins are chosen greedily (all `a` first, then at
// most one `b`), with GAP idle cycles between consecutive pulses. All outputs are registered.
// Optional statistics counters are enabled by defining COIN_SENDER_STAT_EN.
`timescale 1ns/1ps

module coin_sender #(
  parameter int unsigned AMT_W = 8,
  parameter int unsigned GAP   = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  output logic             a,
  output logic             b,
  input  logic             y,
  input  logic             z,
  output logic             busy,
  output logic             done
`ifdef COIN_SENDER_STAT_EN
  ,
  output logic [CNT_W-1:0] item_cnt,
  output logic [CNT_W-1:0] change_cnt
`endif
);

  // Gap counter is sized for GAP; it stays 1 bit wide when GAP is 0.
  localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StCoin,
    StGap,
    StDone
  } state_t;

  state_t             r_state;
  logic [AMT_W-1:0]   r_rem;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_a;
  logic               r_b;
  logic               r_busy;
  logic               r_done;
  logic               r_ready;

  state_t             w_state_nxt;
  logic [AMT_W-1:0]   w_rem_nxt;
  logic [GAP_W-1:0]   w_gap_nxt;
  logic               w_a_nxt;
  logic               w_b_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_ready_nxt;

  // Coin selection shared by every path that issues a coin: from the request on acceptance,
  // from the running remainder otherwise.
  logic [AMT_W-1:0]   w_coin_src;
  logic               w_coin_big;
  logic [AMT_W-1:0]   w_coin_rem;

  // Pick the amount the next coin is drawn from and the greedy coin it yields.
  always_comb begin
    w_coin_src = (r_state == StIdle) ? req_amount : r_rem;
    w_coin_big = (w_coin_src >= AMT_W'(2));
    w_coin_rem = w_coin_src - (w_coin_big ? AMT_W'(2) : AMT_W'(1));
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_gap_nxt   = r_gap_cnt;
    w_a_nxt     = 1'b0;
    w_b_nxt     = 1'b0;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_ready_nxt = r_ready;

    unique case (r_state)
      StIdle: begin
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
        if (req_valid && r_ready) begin
          w_busy_nxt  = 1'b1;
          w_ready_nxt = 1'b0;
          if (req_amount == '0) begin
            // Nothing to pay: complete straight away.
            w_state_nxt = StDone;
            w_rem_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            // First coin appears in the cycle right after acceptance.
            w_state_nxt = StCoin;
            w_a_nxt     = w_coin_big;
            w_b_nxt     = ~w_coin_big;
            w_rem_nxt   = w_coin_rem;
          end
        end
      end

      StCoin: begin
        // r_rem already excludes the coin being shown this cycle.
        if (r_rem == '0) begin
          w_state_nxt = StDone;
          w_done_nxt  = 1'b1;
        end else if (GAP > 0) begin
          w_state_nxt = StGap;
          w_gap_nxt   = GAP_W'(GAP);
        end else begin
          w_state_nxt = StCoin;
          w_a_nxt     = w_coin_big;
          w_b_nxt     = ~w_coin_big;
          w_rem_nxt   = w_coin_rem;
        end
      end

      StGap: begin
        if (r_gap_cnt <= GAP_W'(1)) begin
          w_state_nxt = StCoin;
          w_gap_nxt   = '0;
          w_a_nxt     = w_coin_big;
          w_b_nxt     = ~w_coin_big;
          w_rem_nxt   = w_coin_rem;
        end else begin
          w_gap_nxt = r_gap_cnt - GAP_W'(1);
        end
      end

      StDone: begin
        w_state_nxt = StIdle;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
      end

      default: begin
        w_state_nxt = StIdle;
        w_busy_nxt  = 1'b0;
        w_ready_nxt = 1'b1;
      end
    endcase
  end

  // State and registered outputs; reset drops any payment in flight without a done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= StIdle;
      r_rem     <= '0;
      r_gap_cnt <= '0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ready   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_rem     <= w_rem_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_a       <= w_a_nxt;
      r_b       <= w_b_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign req_ready = r_ready;

`ifdef COIN_SENDER_STAT_EN
  logic [CNT_W-1:0] r_item_cnt;
  logic [CNT_W-1:0] r_change_cnt;

  // Count dispense and change cycles regardless of payment state; counters wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_item_cnt   <= '0;
      r_change_cnt <= '0;
    end else begin
      if (y) r_item_cnt <= r_item_cnt + CNT_W'(1);
      if (z) r_change_cnt <= r_change_cnt + CNT_W'(1);
    end
  end

  assign item_cnt   = r_item_cnt;
  assign change_cnt = r_change_cnt;
`else
  // Machine outputs are only observed for statistics; without them they are unused.
  localparam int unsigned unused_cnt_w = CNT_W;
  logic w_unused_yz;
  assign w_unused_yz = y ^ z;
`endif

endmodule

// File: tb/tb_coin_sender.sv
// Bench for coin_sender: two instances (GAP=1 and GAP=0) driven by randomized payment requests.
// A reference model turns each accepted amount into the expected coin/done timeline and pushes
// it into a scoreboard; a monitor pops and compares on every observed pulse.
`timescale 1ns/1ps

module tb_coin_sender;

  localparam int unsigned AMT_W = 8;

  typedef struct {
    int  id;
    int  cyc;
    byte kind;
  } ev_t;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             req_valid [2];
  logic [AMT_W-1:0] req_amount [2];
  logic             req_ready [2];
  logic             a [2];
  logic             b [2];
  logic             busy [2];
  logic             done [2];
  logic             y;
  logic             z;
`ifdef COIN_SENDER_STAT_EN
  logic [15:0] item_cnt0, change_cnt0;
  logic [1:0]  item_cnt1, change_cnt1;
`endif

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  bsy_from [2];
  int  bsy_to [2];
  int  free_at [2];
  int  m_items = 0;
  int  m_chg = 0;
  ev_t exp_q [$];

  always #5 clk = ~clk;

  coin_sender #(.AMT_W(AMT_W), .GAP(1), .CNT_W(16)) u_dut_gap1 (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid[0]),
    .req_amount(req_amount[0]),
    .req_ready (req_ready[0]),
    .a         (a[0]),
    .b         (b[0]),
    .y         (y),
    .z         (z),
    .busy      (busy[0]),
    .done      (done[0])
`ifdef COIN_SENDER_STAT_EN
    ,
    .item_cnt  (item_cnt0),
    .change_cnt(change_cnt0)
`endif
  );

  coin_sender #(.AMT_W(AMT_W), .GAP(0), .CNT_W(2)) u_dut_gap0 (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid[1]),
    .req_amount(req_amount[1]),
    .req_ready (req_ready[1]),
    .a         (a[1]),
    .b         (b[1]),
    .y         (y),
    .z         (z),
    .busy      (busy[1]),
    .done      (done[1])
`ifdef COIN_SENDER_STAT_EN
    ,
    .item_cnt  (item_cnt1),
    .change_cnt(change_cnt1)
`endif
  );

  function automatic int gap_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic observe(input int d, input byte kind);
    int idx;
    idx = -1;
    checks++;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].id == d) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      errors++;
      $display("FAIL dut%0d event: got %c at cycle %0d, expected no event", d, kind, cyc);
    end else begin
      if (exp_q[idx].kind != kind || exp_q[idx].cyc != cyc) begin
        errors++;
        $display("FAIL dut%0d event: got %c at cycle %0d, expected %c at cycle %0d",
                 d, kind, cyc, exp_q[idx].kind, exp_q[idx].cyc);
      end
      exp_q.delete(idx);
    end
  endtask

  task automatic drop_missing(input int d);
    int i;
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].id == d && exp_q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL dut%0d event: got nothing, expected %c at cycle %0d",
                 d, exp_q[i].kind, exp_q[i].cyc);
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  // Reference model: N units -> N/2 'A' coins then N%2 'B' coins, GAP cycles apart, then done.
  task automatic model_accept(input int d, input int amt, input int c);
    int   n_a, coins, g, t_done;
    ev_t  ev;
    g     = gap_of(d);
    n_a   = amt / 2;
    coins = n_a + (amt % 2);
    for (int k = 0; k < coins; k++) begin
      ev.id   = d;
      ev.cyc  = c + k * (g + 1);
      ev.kind = (k < n_a) ? "A" : "B";
      exp_q.push_back(ev);
    end
    t_done = (coins == 0) ? c : c + coins + (coins - 1) * g;
    ev.id   = d;
    ev.cyc  = t_done;
    ev.kind = "D";
    exp_q.push_back(ev);
    bsy_from[d] = c;
    bsy_to[d]   = t_done;
    free_at[d]  = t_done + 1;
  endtask

  task automatic send(input int d, input int amt, output int c);
    @(negedge clk);
    while (cyc < free_at[d]) @(negedge clk);
    req_valid[d]  = 1'b1;
    req_amount[d] = AMT_W'(amt);
    @(posedge clk);
    #1;
    c = cyc;
    req_valid[d]  = 1'b0;
    req_amount[d] = AMT_W'($urandom);
    model_accept(d, amt, c);
  endtask

  // Request while the model says the block is busy; it must be dropped.
  task automatic poke(input int d, input int amt);
    @(negedge clk);
    if (cyc <= bsy_to[d]) begin
      req_valid[d]  = 1'b1;
      req_amount[d] = AMT_W'(amt);
      @(posedge clk);
      #1;
      req_valid[d]  = 1'b0;
    end
  endtask

  task automatic wait_idle(input int d);
    int n;
    n = 0;
    while (cyc < free_at[d] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk($sformatf("dut%0d idle timeout", d), 1, 0);
  endtask

  task automatic rand_proc(input int d);
    int amt, c;
    for (int i = 0; i < 25; i++) begin
      amt = $urandom_range(0, 12);
      if ($urandom_range(0, 9) == 0) amt = $urandom_range(0, 255);
      send(d, amt, c);
      if ($urandom_range(0, 1) == 1) poke(d, $urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) wait_idle(d);
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef COIN_SENDER_STAT_EN
    chk({tag, " item_cnt cnt16"},   int'(item_cnt0),   m_items % 65536);
    chk({tag, " change_cnt cnt16"}, int'(change_cnt0), m_chg % 65536);
    chk({tag, " item_cnt cnt2"},    int'(item_cnt1),   m_items % 4);
    chk({tag, " change_cnt cnt2"},  int'(change_cnt1), m_chg % 4);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Cycle counter and statistics model, advanced on every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rstn) begin
        if (y) m_items++;
        if (z) m_chg++;
      end
    end
  end

  // Machine-side y/z noise; it must never disturb the coin sequence.
  initial begin
    y = 1'b0;
    z = 1'b0;
    forever begin
      @(negedge clk);
      y = 1'($urandom);
      z = 1'($urandom);
    end
  end

  // Monitor: per-cycle busy/ready/exclusivity checks and scoreboard pops on pulses.
  initial begin
    bit eb;
    forever begin
      @(negedge clk);
      if (rstn) begin
        for (int d = 0; d < 2; d++) begin
          eb = (cyc >= bsy_from[d]) && (cyc <= bsy_to[d]);
          chk($sformatf("dut%0d busy c%0d", d, cyc), int'(busy[d]), int'(eb));
          chk($sformatf("dut%0d req_ready c%0d", d, cyc), int'(req_ready[d]), int'(!eb));
          chk($sformatf("dut%0d a&b c%0d", d, cyc), int'(a[d] & b[d]), 0);
          if (a[d]) observe(d, "A");
          if (b[d]) observe(d, "B");
          if (done[d]) observe(d, "D");
          drop_missing(d);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    for (int d = 0; d < 2; d++) begin
      req_valid[d]  = 1'b0;
      req_amount[d] = '0;
      bsy_from[d]   = 1;
      bsy_to[d]     = 0;
      free_at[d]    = 0;
    end
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset dut%0d a", d), int'(a[d]), 0);
      chk($sformatf("reset dut%0d b", d), int'(b[d]), 0);
      chk($sformatf("reset dut%0d busy", d), int'(busy[d]), 0);
      chk($sformatf("reset dut%0d done", d), int'(done[d]), 0);
      chk($sformatf("reset dut%0d req_ready", d), int'(req_ready[d]), 1);
    end

    // Directed cases: greedy split with gap, zero amount, back-to-back coins, ignored request.
    send(0, 5, c);
    wait_idle(0);
    send(0, 0, c);
    wait_idle(0);
    send(1, 4, c);
    wait_idle(1);
    send(0, 3, c);
    poke(0, 7);
    wait_idle(0);
    send(0, 2, c);
    wait_idle(0);
    check_stats("directed");

    // Reset during the second coin of a 6-unit payment.
    send(0, 6, c);
    while (cyc < c + 2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("mid-reset a", int'(a[0]), 0);
    chk("mid-reset b", int'(b[0]), 0);
    chk("mid-reset busy", int'(busy[0]), 0);
    chk("mid-reset done", int'(done[0]), 0);
    chk("mid-reset req_ready", int'(req_ready[0]), 1);
    exp_q.delete();
    for (int d = 0; d < 2; d++) begin
      bsy_from[d] = 1;
      bsy_to[d]   = 0;
      free_at[d]  = 0;
    end
    m_items = 0;
    m_chg   = 0;
    @(negedge clk);
    #1 rstn = 1'b1;
    repeat (6) @(negedge clk);
    check_stats("after reset");

    // Randomized traffic on both instances at once.
    fork
      rand_proc(0);
      rand_proc(1);
    join
    wait_idle(0);
    wait_idle(1);
    repeat (2) @(negedge clk);
    check_stats("final");
    chk("scoreboard leftover events", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
